// File: rtl/uart_pkg.sv
// Shared UART baud constants: divisor width, select codes, FSM encoding
// and the select-to-divisor table (100 MHz system clock).
package uart_pkg;

  localparam int K_W = 19;

  localparam logic [3:0] BAUD_300    = 4'b0000;
  localparam logic [3:0] BAUD_1200   = 4'b0001;
  localparam logic [3:0] BAUD_2400   = 4'b0010;
  localparam logic [3:0] BAUD_4800   = 4'b0011;
  localparam logic [3:0] BAUD_9600   = 4'b0100;
  localparam logic [3:0] BAUD_19200  = 4'b0101;
  localparam logic [3:0] BAUD_38400  = 4'b0110;
  localparam logic [3:0] BAUD_57600  = 4'b0111;
  localparam logic [3:0] BAUD_115200 = 4'b1000;
  localparam logic [3:0] BAUD_230400 = 4'b1001;
  localparam logic [3:0] BAUD_460800 = 4'b1010;
  localparam logic [3:0] BAUD_921600 = 4'b1011;

  localparam logic [3:0] RST_BAUD = BAUD_115200;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PEND = 2'd1,
    ST_LOAD = 2'd2
  } baud_state_e;

  // Unused codes fall back to the slowest rate rather than being rejected.
  function automatic logic [K_W-1:0] baud_k(input logic [3:0] sel);
    logic [K_W-1:0] k;
    case (sel)
      BAUD_300:    k = K_W'(333333);
      BAUD_1200:   k = K_W'(83333);
      BAUD_2400:   k = K_W'(41667);
      BAUD_4800:   k = K_W'(20833);
      BAUD_9600:   k = K_W'(10417);
      BAUD_19200:  k = K_W'(5208);
      BAUD_38400:  k = K_W'(2604);
      BAUD_57600:  k = K_W'(1736);
      BAUD_115200: k = K_W'(868);
      BAUD_230400: k = K_W'(434);
      BAUD_460800: k = K_W'(217);
      BAUD_921600: k = K_W'(109);
      default:     k = K_W'(333333);
    endcase
    return k;
  endfunction

endpackage

// File: rtl/uart_baud_ctrl_decoder.sv
// Combinational baud select to clock-divisor lookup.
module baud_decoder #(
  parameter int K_W = uart_pkg::K_W
) (
  input  logic [3:0]     sel_i,
  output logic [K_W-1:0] k_o
);
  import uart_pkg::*;

  assign k_o = K_W'(baud_k(sel_i));

endmodule

// File: rtl/uart_baud_ctrl.sv
// UART baud-rate owner: defers select changes until TX and RX are idle,
// then runs the divisor counter that emits bit and half-bit ticks.
//
// state | meaning
// RUN   | active setting in use, no write queued
// PEND  | write queued, waiting for tx_busy = rx_busy = 0
// LOAD  | one cycle: apply queued select/divisor, clear counter
module uart_baud_ctrl #(
  parameter int         K_W      = uart_pkg::K_W,
  parameter logic [3:0] RST_BAUD = uart_pkg::RST_BAUD
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           baud_wr,
  input  logic [3:0]     baud_din,
  input  logic           tx_busy,
  input  logic           rx_busy,
  input  logic           tick_en,
  input  logic           tick_clr,
  output logic [3:0]     baud_sel,
  output logic [K_W-1:0] k_active,
  output logic           pending,
  output logic           bit_tick,
  output logic           half_tick
);
  import uart_pkg::*;

  localparam logic [K_W-1:0] RST_K = K_W'(baud_k(RST_BAUD));

  baud_state_e    state_q, state_d;
  logic [3:0]     pend_sel_q, pend_sel_d;
  logic [3:0]     baud_sel_q;
  logic [K_W-1:0] k_active_q;
  logic [K_W-1:0] cnt_q, cnt_d;
  logic [K_W-1:0] k_dec, k_last, k_half_last;
  logic           bit_tick_q, bit_tick_d;
  logic           half_tick_q, half_tick_d;

  baud_decoder #(.K_W(K_W)) u_dec (
    .sel_i (pend_sel_q),
    .k_o   (k_dec)
  );

  always_comb begin
    state_d    = state_q;
    pend_sel_d = pend_sel_q;
    if (baud_wr) pend_sel_d = baud_din;
    case (state_q)
      ST_RUN:  if (baud_wr) state_d = ST_PEND;
      ST_PEND: if (!tx_busy && !rx_busy) state_d = ST_LOAD;
      ST_LOAD: state_d = baud_wr ? ST_PEND : ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  assign k_last      = k_active_q - K_W'(1);
  assign k_half_last = (k_active_q >> 1) - K_W'(1);

  // A clear takes priority over a terminal count, so no tick escapes it.
  always_comb begin
    cnt_d       = cnt_q;
    bit_tick_d  = 1'b0;
    half_tick_d = 1'b0;
    if (state_q == ST_LOAD || tick_clr) begin
      cnt_d = '0;
    end else if (tick_en) begin
      half_tick_d = (cnt_q == k_half_last);
      if (cnt_q == k_last) begin
        cnt_d      = '0;
        bit_tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + K_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      pend_sel_q  <= RST_BAUD;
      baud_sel_q  <= RST_BAUD;
      k_active_q  <= RST_K;
      cnt_q       <= '0;
      bit_tick_q  <= 1'b0;
      half_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_sel_q  <= pend_sel_d;
      cnt_q       <= cnt_d;
      bit_tick_q  <= bit_tick_d;
      half_tick_q <= half_tick_d;
      if (state_q == ST_LOAD) begin
        baud_sel_q <= pend_sel_q;
        k_active_q <= k_dec;
      end
    end
  end

  assign baud_sel  = baud_sel_q;
  assign k_active  = k_active_q;
  assign pending   = (state_q != ST_RUN);
  assign bit_tick  = bit_tick_q;
  assign half_tick = half_tick_q;

endmodule

// File: doc/uart_baud_ctrl.md
# uart_baud_ctrl

- Owns the UART's active baud-rate setting and turns it into timing strobes.
- Accepts baud-select writes from the Tramelblaze output port and defers each change until both transmitter and receiver are idle.
- Converts the 4-bit select to a 19-bit divisor through `baud_decoder`, then runs the divisor counter that produces full-bit and half-bit ticks.
- Sits between the processor I/O decode and the `tx_engine`/`rx_engine` blocks.

## Interface
Parameters:
- `K_W`, 19: divisor width; must match the `baud_decoder` output.
- `RST_BAUD`, 4'b1000: select loaded at reset (115200, k=868).

Ports:
- `clk`  in  1  system clock (100 MHz).
- `reset_n`  in  1  synchronous, active-low reset.
- `baud_wr`  in  1  one-cycle write strobe from port decode.
- `baud_din`  in  4  requested baud select.
- `tx_busy`  in  1  transmitter mid-frame.
- `rx_busy`  in  1  receiver mid-frame.
- `tick_en`  in  1  divisor counter run enable.
- `tick_clr`  in  1  restart the counter; used at RX start-bit detect and TX frame start.
- `baud_sel`  out  4  active select.
- `k_active`  out  K_W  active divisor (registered).
- `pending`  out  1  a write is waiting to be applied.
- `bit_tick`  out  1  one-cycle pulse, once per bit period.
- `half_tick`  out  1  one-cycle pulse at mid-bit.

## Operation
- FSM states: RUN, PEND, LOAD.
- RUN:
  - `baud_wr` captures `baud_din` into `pend_sel` and moves to PEND.
- PEND:
  - `baud_wr` overwrites `pend_sel`, so the last write wins.
  - When `tx_busy`=0 and `rx_busy`=0 in the same cycle, move to LOAD. Otherwise hold.
- LOAD (exactly one cycle):
  - `baud_sel` takes `pend_sel`; `k_active` takes the decoder output for `pend_sel`; `cnt` clears to 0.
  - Ticks are suppressed and the counter does not advance.
  - Then return to RUN.
  - A `baud_wr` during LOAD is captured into `pend_sel` and the next state is PEND, not RUN.
- `pending` = (state == PEND) or (state == LOAD).
- Codes 4'b1100–4'b1111 are accepted unchanged. The decoder maps them to k=333333, and `baud_sel` reports the raw code.
- Counter (`cnt`, K_W bits, outside LOAD):
  - `tick_clr`=1: `cnt` ← 0. This has priority and works regardless of `tick_en`.
  - Else `tick_en`=1 and `cnt` == `k_active`−1: `cnt` ← 0 and `bit_tick` is set next cycle.
  - Else `tick_en`=1: `cnt` ← `cnt`+1.
  - `tick_en`=0: `cnt` holds and no ticks are produced.
- `half_tick` is set next cycle when `tick_en`=1, `tick_clr`=0 and `cnt` == (`k_active`>>1)−1. The shift floors: k=109 gives 54.
- Arithmetic is unsigned K_W-bit. k ≥ 109 always, so k−1 and half−1 never underflow.
- Reset (any cycle, including mid-PEND or mid-LOAD) gives:
  - state RUN, `baud_sel`=`RST_BAUD`, `k_active`=868, `cnt`=0;
  - `pending`=0, `bit_tick`=0, `half_tick`=0;
  - any queued write is discarded.

## Timing
- All outputs are registered; nothing is combinational from inputs to outputs.
- Write latency with the UART idle:
  - `baud_wr` in cycle c leads to `pending`=1 from c+1, LOAD in c+2.
  - New `baud_sel`/`k_active` and `cnt`=0 are visible from c+3.
- If busy, the apply is deferred. LOAD occurs in the cycle after the first cycle in which both busies are low.
- Counter restart latency:
  - `tick_clr` in cycle c gives `cnt`=0 in c+1.
  - `half_tick` is high in cycle c+1+half; `bit_tick` is high in cycle c+1+k.
- Steady-state `bit_tick` period is exactly `k_active` cycles, with pulse width 1.
- Simultaneous `tick_clr` and terminal count: the clear wins and no tick is issued.

## Structure
- Shared package `uart_pkg`:
  - `K_W`;
  - the baud select codes (`BAUD_300` … `BAUD_921600`);
  - `RST_BAUD`;
  - FSM state encoding.
- One sub-module, `baud_decoder`, instantiated with `pend_sel` as input. Its output is registered into `k_active` only in LOAD.
- Expected size: about 150 lines of RTL.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles, then release. Expect `baud_sel`=4'b1000, `k_active`=868, `pending`=0; with `tick_en`=1, `bit_tick` pulses every 868 cycles.
- Idle change: write 4'b1011 in cycle c with both busies low. Expect `k_active`=109 at c+3, then a 109-cycle `bit_tick` period.
- Deferred change: `tx_busy`=1, write 4'b0101. Expect `pending` to stay 1 and k to stay 868. Drop `tx_busy` at cycle d; expect `k_active`=5208 at d+2.
- Last write wins: while `rx_busy`=1, write 4'b0010, then 4'b1001. Release busy; expect `k_active`=434 and `baud_sel`=4'b1001.
- Invalid code: write 4'b1111. Expect `baud_sel`=4'b1111 and `k_active`=333333.
- Mid-bit alignment at k=109: pulse `tick_clr` in cycle c. Expect `half_tick` at c+55 and `bit_tick` at c+110. Assert `reset_n`=0 during PEND; expect `pending`=0 and k=868.
